// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite master: one write or read per accepted command, completion on rsp.
// Optional watchdog compiled in when AXIL_MASTER_TIMEOUT_EN is defined.
module axil_master #(
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 4,
    parameter int unsigned C_TIMEOUT_CYCLES   = 256
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY,
    output logic                              timeout_err
);

    localparam int unsigned StrbW = C_M_AXI_DATA_WIDTH / 8;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StWaddr = 3'd1;
    localparam logic [2:0] StWresp = 3'd2;
    localparam logic [2:0] StRaddr = 3'd3;
    localparam logic [2:0] StRdata = 3'd4;
    localparam logic [2:0] StRsp   = 3'd5;

    if (C_M_AXI_DATA_WIDTH != 32 && C_M_AXI_DATA_WIDTH != 64) begin : g_bad_width
        $error("axil_master: C_M_AXI_DATA_WIDTH must be 32 or 64");
    end
    if (C_TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("axil_master: C_TIMEOUT_CYCLES must be non-zero");
    end

    logic [2:0]                    state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [StrbW-1:0]              wstrb_q, wstrb_d;
    logic                          awvalid_q, awvalid_d;
    logic                          wvalid_q, wvalid_d;
    logic                          arvalid_q, arvalid_d;
    logic                          bready_q, bready_d;
    logic                          rready_q, rready_d;
    logic                          rsp_valid_q, rsp_valid_d;
    logic                          rsp_write_q, rsp_write_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                    rsp_resp_q, rsp_resp_d;
    logic                          accept;

    assign cmd_ready = (state_q == StIdle);
    assign accept    = cmd_valid & cmd_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    rsp_write_d = cmd_write;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StWaddr;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = StRaddr;
                    end
                end
            end
            StWaddr: begin
                // AW and W complete independently; leave once both are done.
                if (M_AXI_AWREADY) awvalid_d = 1'b0;
                if (M_AXI_WREADY)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = StWresp;
                end
            end
            StWresp: begin
                if (M_AXI_BVALID) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = M_AXI_BRESP;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = StRsp;
                end
            end
            StRaddr: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRdata;
                end
            end
            StRdata: begin
                if (M_AXI_RVALID) begin
                    rready_d    = 1'b0;
                    rsp_resp_d  = M_AXI_RRESP;
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_valid_d = 1'b1;
                    state_d     = StRsp;
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(C_TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            tmo_err_q, tmo_err_d;
    logic            busy;

    assign busy = state_q inside {StWaddr, StWresp, StRaddr, StRdata};

    // Counter saturates at the limit; the flag only reports, it never aborts the transaction.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (accept) begin
            tmo_cnt_d = '0;
        end else if (busy && tmo_cnt_q != CntW'(C_TIMEOUT_CYCLES)) begin
            tmo_cnt_d = tmo_cnt_q + CntW'(1);
        end
        tmo_err_d = tmo_err_q | (tmo_cnt_d == CntW'(C_TIMEOUT_CYCLES));
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axil_master.sv
// Bench for axil_master: randomized AXI4-Lite slave with latency knobs, reference memory model,
// protocol stability checks and directed write/read/backpressure/reset/watchdog scenarios.
module tb_axil_master;

    localparam int TMO = 16;
`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        timeout_err;

    axil_master #(
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(4),
        .C_TIMEOUT_CYCLES  (TMO)
    ) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESETN(rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_write    (rsp_write),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .M_AXI_AWADDR (awaddr),
        .M_AXI_AWPROT (awprot),
        .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA  (wdata),
        .M_AXI_WSTRB  (wstrb),
        .M_AXI_WVALID (wvalid),
        .M_AXI_WREADY (wready),
        .M_AXI_BRESP  (bresp),
        .M_AXI_BVALID (bvalid),
        .M_AXI_BREADY (bready),
        .M_AXI_ARADDR (araddr),
        .M_AXI_ARPROT (arprot),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA  (rdata),
        .M_AXI_RRESP  (rresp),
        .M_AXI_RVALID (rvalid),
        .M_AXI_RREADY (rready),
        .timeout_err  (timeout_err)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Slave knobs and slave-side state
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]  bresp_k, rresp_k;
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit          aw_f, w_f, r_arm;
    logic [3:0]  aw_cap, ar_cap, strb_cap;
    logic [31:0] w_cap, r_data_k;
    logic [31:0] smem [4];
    int          n_b, n_b_exp;

    // Protocol monitor history
    bit          aw_pend, w_pend, ar_pend, aw_hs_p, w_hs_p, ar_hs_p;
    logic [3:0]  aw_prev, ar_prev, strb_prev;
    logic [31:0] w_prev;

    // Reference model
    logic [31:0] ref_mem [4];
    bit          tmo_exp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Slave drive on the falling edge
    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
            end else begin
                if (!awvalid) begin awready = 0; aw_wait = 0; end
                else if (aw_wait >= aw_dly) awready = 1;
                else begin awready = 0; aw_wait++; end
                if (!wvalid) begin wready = 0; w_wait = 0; end
                else if (w_wait >= w_dly) wready = 1;
                else begin wready = 0; w_wait++; end
                if (!(aw_f && w_f)) begin bvalid = 0; b_wait = 0; end
                else if (b_wait >= b_dly) begin bvalid = 1; bresp = bresp_k; end
                else b_wait++;
                if (!arvalid) begin arready = 0; ar_wait = 0; end
                else if (ar_wait >= ar_dly) arready = 1;
                else begin arready = 0; ar_wait++; end
                if (!r_arm) begin rvalid = 0; r_wait = 0; end
                else if (r_wait >= r_dly) begin rvalid = 1; rdata = r_data_k; rresp = rresp_k; end
                else r_wait++;
            end
        end
    end

    // Handshake bookkeeping and AXI stability checks on the rising edge
    always @(posedge clk) begin
        if (!rst_n) begin
            aw_f = 0; w_f = 0; r_arm = 0;
            aw_pend = 0; w_pend = 0; ar_pend = 0; aw_hs_p = 0; w_hs_p = 0; ar_hs_p = 0;
        end else begin
            if (aw_pend) begin
                chk("awvalid_held", awvalid, 1'b1);
                chk("awaddr_stable", awaddr, aw_prev);
            end
            if (w_pend) begin
                chk("wvalid_held", wvalid, 1'b1);
                chk("wdata_stable", {wstrb, wdata}, {strb_prev, w_prev});
            end
            if (ar_pend) begin
                chk("arvalid_held", arvalid, 1'b1);
                chk("araddr_stable", araddr, ar_prev);
            end
            if (aw_hs_p) chk("awvalid_drop", awvalid, 1'b0);
            if (w_hs_p)  chk("wvalid_drop", wvalid, 1'b0);
            if (ar_hs_p) chk("arvalid_drop", arvalid, 1'b0);
            if (awvalid || arvalid) chk("prot_zero", {awprot, arprot}, 6'd0);
            aw_pend = awvalid && !awready; aw_prev = awaddr;
            w_pend  = wvalid && !wready;   w_prev = wdata; strb_prev = wstrb;
            ar_pend = arvalid && !arready; ar_prev = araddr;
            aw_hs_p = awvalid && awready;
            w_hs_p  = wvalid && wready;
            ar_hs_p = arvalid && arready;
            if (awvalid && awready) begin aw_f = 1; aw_cap = awaddr; end
            if (wvalid && wready) begin w_f = 1; w_cap = wdata; strb_cap = wstrb; end
            if (bvalid && bready) begin
                n_b++;
                aw_f = 0; w_f = 0;
                for (int b = 0; b < 4; b++)
                    if (strb_cap[b]) smem[aw_cap[3:2]][8*b +: 8] = w_cap[8*b +: 8];
            end
            if (arvalid && arready) begin
                ar_cap = araddr; r_data_k = smem[araddr[3:2]]; r_arm = 1;
            end
            if (rvalid && rready) r_arm = 0;
        end
    end

    task automatic do_cmd(input bit wr, input logic [3:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input int bp);
        int          lat, exp_lat;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        if (wr) begin
            exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
            for (int b = 0; b < 4; b++)
                if (ws[b]) ref_mem[addr[3:2]][8*b +: 8] = wd[8*b +: 8];
            exp_rdata = '0;
            exp_resp  = bresp_k;
            n_b_exp++;
        end else begin
            exp_lat   = 3 + ar_dly + r_dly;
            exp_rdata = ref_mem[addr[3:2]];
            exp_resp  = rresp_k;
        end
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (TmoEn && (lat - 1) >= TMO) tmo_exp = 1'b1;
            chk("timeout_err", timeout_err, tmo_exp);
            if (!rsp_valid) chk("cmd_ready_busy", cmd_ready, 1'b0);
        end while (!rsp_valid && lat < 200);
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("latency", lat, exp_lat);
        chk("rsp_write", rsp_write, wr);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_resp", rsp_resp, exp_resp);
        if (wr) begin
            chk("awaddr_seen", aw_cap, addr);
            chk("wdata_seen", w_cap, wd);
            chk("wstrb_seen", strb_cap, ws);
            chk("b_count", n_b, n_b_exp);
        end else begin
            chk("araddr_seen", ar_cap, addr);
        end
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_cmd_ready", cmd_ready, 1'b0);
            chk("bp_rsp_fields", {rsp_write, rsp_resp, rsp_rdata}, {wr, exp_resp, exp_rdata});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("rsp_done", rsp_valid, 1'b0);
        chk("cmd_ready_after", cmd_ready, 1'b1);
        chk("b_count_final", n_b, n_b_exp);
    endtask

    initial begin
        rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0;
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; bresp_k = 0; rresp_k = 0;
        n_b = 0; n_b_exp = 0; tmo_exp = 0;
        for (int i = 0; i < 4; i++) begin ref_mem[i] = '0; smem[i] = '0; end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'd0);
        chk("rst_rsp_regs", {rsp_write, rsp_resp, rsp_rdata}, 35'd0);
        chk("rst_axi_regs", {awaddr, wdata, wstrb}, 40'd0);
        chk("rst_timeout", timeout_err, 1'b0);
        @(negedge clk);
        rst_n = 1;

        do_cmd(1'b1, 4'h4, 32'hDEAD_BEEF, 4'hF, 0);
        w_dly = 0; aw_dly = 2;
        do_cmd(1'b1, 4'h8, 32'h1234_5678, 4'hF, 0);
        aw_dly = 0; rresp_k = 2'b10;
        do_cmd(1'b0, 4'h4, 32'h0, 4'h0, 0);
        bresp_k = 2'b01;
        do_cmd(1'b1, 4'hC, 32'hA5A5_C3C3, 4'b0101, 5);
        bresp_k = 2'b00; rresp_k = 2'b00; ar_dly = 20;
        do_cmd(1'b0, 4'h8, 32'h0, 4'h0, 0);
        ar_dly = 0;

        for (int i = 0; i < 24; i++) begin
            aw_dly  = $urandom_range(0, 3);
            w_dly   = $urandom_range(0, 3);
            b_dly   = $urandom_range(0, 3);
            ar_dly  = $urandom_range(0, 3);
            r_dly   = $urandom_range(0, 3);
            bresp_k = 2'($urandom_range(0, 3));
            rresp_k = 2'($urandom_range(0, 3));
            do_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                   4'($urandom_range(0, 15)), $urandom_range(0, 3));
        end

        // Abandon a write mid-flight with an asynchronous reset
        aw_dly = 100; w_dly = 100; b_dly = 0; ar_dly = 0; r_dly = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h8; cmd_wdata = 32'hFFFF_0000; cmd_wstrb = 4'hF;
        @(posedge clk); #1;
        cmd_valid = 0;
        @(posedge clk); #1;
        chk("pre_reset_awvalid", awvalid, 1'b1);
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'd0);
        chk("async_rst_cmd_ready", cmd_ready, 1'b1);
        chk("async_rst_awaddr", awaddr, 4'h0);
        chk("async_rst_timeout", timeout_err, 1'b0);
        tmo_exp = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1; aw_dly = 0; w_dly = 0;
        @(posedge clk); #1;
        chk("release_cmd_ready", cmd_ready, 1'b1);

        rresp_k = 2'b00;
        do_cmd(1'b0, 4'h8, 32'h0, 4'h0, 1);
        do_cmd(1'b0, 4'h4, 32'h0, 4'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_master.md
# axil_master

Single-outstanding AXI4-Lite master. It converts a simple valid/ready command port into one AXI4-Lite write or read transaction at a time. It returns the completion (read data and response code) on a valid/ready response port. It sits between user logic or a bus bridge and any AXI4-Lite slave register block in the design, such as the UART register file.

## Interface
- C_M_AXI_DATA_WIDTH, 32, data width; 32 or 64
- C_M_AXI_ADDR_WIDTH, 4, address width
- C_TIMEOUT_CYCLES, 256, watchdog limit; used only with the macro in Configuration
- M_AXI_ACLK  in  1  clock; all logic on rising edge
- M_AXI_ARESETN  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR  byte address
- cmd_wdata  in  DATA  write data
- cmd_wstrb  in  DATA/8  byte enables
- rsp_valid / rsp_ready  out/in  1  response handshake
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  DATA  read data; 0 for writes
- rsp_resp  out  2  BRESP or RRESP as received
- M_AXI_AWADDR, AWPROT(3), AWVALID out; AWREADY in
- M_AXI_WDATA, WSTRB, WVALID out; WREADY in
- M_AXI_BRESP(2), BVALID in; BREADY out
- M_AXI_ARADDR, ARPROT(3), ARVALID out; ARREADY in
- M_AXI_RDATA, RRESP(2), RVALID in; RREADY out
- timeout_err  out  1  sticky watchdog flag

## Operation
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, RSP.
- cmd_ready = (state == IDLE). A command is accepted on cmd_valid & cmd_ready.
  - On accept, the block registers addr, wdata and wstrb into the AXI output registers.
  - A write goes to WADDR; a read goes to RADDR.
- WADDR:
  - AWVALID and WVALID are both asserted.
  - Each one drops independently on its own handshake (VALID & READY).
  - The FSM goes to WRESP once both handshakes are done, whether they happen in the same cycle or in different cycles.
- WRESP: BREADY = 1. On BVALID, the block captures BRESP, sets rsp_rdata = 0, and goes to RSP.
- RADDR: ARVALID = 1. On ARREADY, ARVALID drops and the FSM goes to RDATA.
- RDATA: RREADY = 1. On RVALID, the block captures RDATA and RRESP and goes to RSP.
- RSP:
  - rsp_valid = 1; the response fields are held stable.
  - On rsp_ready the FSM returns to IDLE.
  - No new command is accepted before that handshake.
- AWPROT = ARPROT = 3'b000 always.
- The AXI address, data and strobe outputs are held stable while the corresponding VALID is high.
- Once asserted, a VALID is never dropped before its handshake.
- The BRESP/RRESP value is passed through unmodified; the block never generates error codes.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - All VALID and READY outputs go to 0.
  - The address, data, strobe, rsp_rdata, rsp_resp and rsp_write registers go to 0.
  - timeout_err goes to 0.
- Reset during any state abandons the transaction; cmd_ready = 1 on the first edge after release.
- AWVALID/WVALID/ARVALID rise on the clock edge after command accept (1-cycle latency).
- BREADY/RREADY are registered state decodes: high from the first cycle of WRESP/RDATA.
- A BVALID or RVALID that arrives in the first cycle of WRESP/RDATA is captured on that edge.
- rsp_valid rises on the edge after the B or R handshake.
- Minimum command-to-response latency:
  - Write: 3 cycles (accept, AW/W handshake, B handshake).
  - Read: 3 cycles (accept, AR handshake, R handshake).
- Throughput: with rsp_ready held high, one transaction every 4 cycles minimum (RSP is one cycle).
- Slave responses that are not expected in the current state are ignored; READY stays low.

## Configuration
- AXIL_MASTER_TIMEOUT_EN defined:
  - A counter clears on command accept and increments each cycle in WADDR, WRESP, RADDR or RDATA.
  - When the count reaches C_TIMEOUT_CYCLES, timeout_err is set and stays set until reset.
  - The transaction is not aborted; the FSM keeps waiting, so the AXI rules are preserved.
- Not defined: no counter logic; timeout_err is tied to 0.

## Test plan
- Write: cmd addr 0x4, data 0xDEADBEEF, wstrb 0xF; slave readies AW/W together and returns BRESP 0 -> AWADDR 0x4 and WDATA 0xDEADBEEF presented; rsp_valid with rsp_write 1, rsp_resp 0, rsp_rdata 0; 3-cycle minimum latency.
- Split write: slave accepts W 2 cycles before AW -> WVALID drops after its handshake, AWVALID held until AWREADY, exactly one B handshake, a single response.
- Read back addr 0x4 with RRESP 2'b10 -> ARADDR 0x4, rsp_rdata 0xDEADBEEF, rsp_resp 2'b10, rsp_write 0.
- Backpressure: rsp_ready low for 5 cycles, cmd_valid held high -> cmd_ready stays 0 and response fields stable; next command accepted only after the rsp handshake.
- Reset mid-transaction: deassert M_AXI_ARESETN while AWVALID = 1 -> all VALIDs 0 immediately, cmd_ready 1 after release.
- With AXIL_MASTER_TIMEOUT_EN and C_TIMEOUT_CYCLES = 16: read with ARREADY held low -> timeout_err rises after 16 cycles, ARVALID stays high, and timeout_err stays 1 after a later successful completion.
